// File: rtl/pll_pkg.sv
// Shared types and defaults for the PLL lock supervisor and its users.
// Pure declarations: no latency, no flow control.
package pll_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int FILTER_CYCLES_DEF = 64;
  localparam int HOLD_CYCLES_DEF   = 1024;

  // Counter only ever reaches max-1, so $clog2(max) bits suffice; floor at 1 bit.
  function automatic int cnt_width(input int filter_cycles, input int hold_cycles);
    int m;
    m = (filter_cycles > hold_cycles) ? filter_cycles : hold_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Lock/reset/status bundle between the PLL-side driver and the lock supervisor.
// Wires only: no latency, no flow control.
interface pll_lock_supervisor_if #(
  parameter int CNT_W = 8
);
  logic             locked;
  logic             clr_stats;
  logic             sys_rst_n;
  logic             ready;
  logic [CNT_W-1:0] loss_count;
  logic             glitch_seen;

  modport master (
    output locked,
    output clr_stats,
    input  sys_rst_n,
    input  ready,
    input  loss_count,
    input  glitch_seen
  );

  modport slave (
    input  locked,
    input  clr_stats,
    output sys_rst_n,
    output ready,
    output loss_count,
    output glitch_seen
  );
endinterface

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with async clear, for any CDC point.
// Latency: STAGES clocks from d to q; no backpressure.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Turns PLL 'locked' into a filtered, held system reset and tracks lock-loss stats.
// Latency: lock-to-release SYNC_STAGES+FILTER_CYCLES+HOLD_CYCLES+1, loss-to-reset 1 after lk; no backpressure.
module pll_lock_supervisor
  import pll_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int CNT_W         = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  pll_lock_supervisor_if.slave pll
);

  localparam int            CW          = cnt_width(FILTER_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] FILTER_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             lk;
  logic             loss_ev;
  logic             glitch_ev;
  logic             sys_rst_q;
  logic             ready_q;
  logic [CNT_W-1:0] loss_q;
  logic             glitch_q;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (pll.locked),
    .q       (lk)
  );

  assign loss_ev   = (state == RUN) && !lk;
  assign glitch_ev = ((state == FILTER) || (state == HOLD)) && !lk;

  // sys_rst_n/ready are set on the same edge that enters/leaves RUN so they stay flop outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      sys_rst_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          cnt <= '0;
          if (lk) begin
            state <= FILTER;
          end
        end
        FILTER: begin
          if (!lk) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == FILTER_LAST) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!lk) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lk) begin
            state     <= WAIT_LOCK;
            sys_rst_q <= 1'b0;
            ready_q   <= 1'b0;
          end
        end
        default: begin
          state     <= WAIT_LOCK;
          cnt       <= '0;
          sys_rst_q <= 1'b0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  // A clear coinciding with an event restarts the stat from that event.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      loss_q   <= '0;
      glitch_q <= 1'b0;
    end else begin
      if (loss_ev) begin
        if (pll.clr_stats) begin
          loss_q <= CNT_W'(1);
        end else if (loss_q != '1) begin
          loss_q <= loss_q + 1'b1;
        end
      end else if (pll.clr_stats) begin
        loss_q <= '0;
      end

      if (glitch_ev) begin
        glitch_q <= 1'b1;
      end else if (pll.clr_stats) begin
        glitch_q <= 1'b0;
      end
    end
  end

  assign pll.sys_rst_n   = sys_rst_q;
  assign pll.ready       = ready_q;
  assign pll.loss_count  = loss_q;
  assign pll.glitch_seen = glitch_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: default-size latency sequences, a tiny-config vector table,
// and a randomized run of a small config against a run-length reference model.
module tb_pll_lock_supervisor;

  logic clock = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;

  always #5 clock = ~clock;

  pll_lock_supervisor_if #(.CNT_W(8)) ifa ();
  pll_lock_supervisor_if #(.CNT_W(2)) ifb ();
  pll_lock_supervisor_if #(.CNT_W(2)) ifc ();

  pll_lock_supervisor #(
    .SYNC_STAGES(2), .FILTER_CYCLES(64), .HOLD_CYCLES(1024), .CNT_W(8)
  ) dut_a (
    .clock(clock), .reset_n(rst_a), .pll(ifa)
  );

  pll_lock_supervisor #(
    .SYNC_STAGES(2), .FILTER_CYCLES(4), .HOLD_CYCLES(8), .CNT_W(2)
  ) dut_b (
    .clock(clock), .reset_n(rst_b), .pll(ifb)
  );

  pll_lock_supervisor #(
    .SYNC_STAGES(2), .FILTER_CYCLES(1), .HOLD_CYCLES(1), .CNT_W(2)
  ) dut_c (
    .clock(clock), .reset_n(rst_c), .pll(ifc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Edges until instance A releases sys_rst_n; the first edge after the call counts as 1.
  task automatic rise_a(output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (ifa.sys_rst_n !== 1'b1 && n < 3000);
  endtask

  // Reference model for instance B: lock is accepted once the synchronized flag
  // has been high for FILTER+HOLD+1 consecutive sampling edges.
  localparam int BS   = 2;
  localparam int BF   = 4;
  localparam int BH   = 8;
  localparam int BMAX = 3;

  int bh[$];
  int br    = 0;
  int bloss = 0;
  bit bgl   = 1'b0;
  bit brdy  = 1'b0;

  task automatic model_b_reset();
    bh.delete();
    br    = 0;
    bloss = 0;
    bgl   = 1'b0;
    brdy  = 1'b0;
  endtask

  task automatic model_b_edge();
    int lk;
    bit lev;
    bit gev;
    bit clr;
    lk = (bh.size() == BS) ? bh[0] : 0;
    bh.push_back(ifb.locked ? 1 : 0);
    if (bh.size() > BS) void'(bh.pop_front());
    clr = ifb.clr_stats;
    lev = (lk == 0) && (br >= BF + BH + 1);
    gev = (lk == 0) && (br >= 1) && (br <= BF + BH);
    br  = (lk == 0) ? 0 : ((br < 1000000) ? br + 1 : br);
    if (lev) bloss = clr ? 1 : ((bloss < BMAX) ? bloss + 1 : BMAX);
    else if (clr) bloss = 0;
    if (gev) bgl = 1'b1;
    else if (clr) bgl = 1'b0;
    brdy = (br >= BF + BH + 1);
  endtask

  task automatic step_b();
    logic [1:0] el;
    @(posedge clock);
    model_b_edge();
    #1;
    el = bloss[1:0];
    check("b_cyc", {ifb.sys_rst_n, ifb.ready, ifb.loss_count, ifb.glitch_seen},
          {brdy, brdy, el, bgl});
  endtask

  typedef struct {
    int locked;
    int clr;
    int rdy;
    int loss;
    int glitch;
  } vec_t;

  vec_t tbl[29];

  initial begin
    int n;
    int hi;
    int lo;
    logic [1:0] el;

    tbl = '{
      '{1,0,0,0,0}, '{1,0,0,0,0}, '{1,0,0,0,0}, '{1,0,0,0,0}, '{1,0,1,0,0},
      '{0,0,1,0,0}, '{1,0,1,0,0}, '{1,0,0,1,0}, '{1,1,0,0,0}, '{0,0,0,0,0},
      '{1,0,1,0,0}, '{1,0,0,1,0}, '{0,0,0,1,0}, '{1,1,0,0,0}, '{1,0,0,0,1},
      '{1,1,0,0,0}, '{1,0,0,0,0}, '{1,0,1,0,0}, '{0,0,1,0,0}, '{1,0,1,0,0},
      '{1,0,0,1,0}, '{1,0,0,1,0}, '{1,0,0,1,0}, '{0,0,1,1,0}, '{1,0,1,1,0},
      '{1,1,0,1,0}, '{0,0,0,1,0}, '{1,1,0,0,0}, '{1,1,0,0,1}
    };

    ifa.locked = 1'b1;
    ifa.clr_stats = 1'b0;
    ifb.locked = 1'b0;
    ifb.clr_stats = 1'b0;
    ifc.locked = 1'b0;
    ifc.clr_stats = 1'b0;

    repeat (5) @(posedge clock);
    #1;
    check("a_rst", {ifa.sys_rst_n, ifa.ready, ifa.loss_count, ifa.glitch_seen}, 0);
    check("b_rst", {ifb.sys_rst_n, ifb.ready, ifb.loss_count, ifb.glitch_seen}, 0);
    check("c_rst", {ifc.sys_rst_n, ifc.ready, ifc.loss_count, ifc.glitch_seen}, 0);

    // Power-up with lock already asserted.
    rst_a = 1'b1;
    rise_a(n);
    check("pwr_lat", n, 1091);
    check("pwr_rdy", ifa.ready, 1);

    // One-cycle lock drop while running.
    ifa.locked = 1'b0;
    @(posedge clock);
    #1;
    ifa.locked = 1'b1;
    @(posedge clock);
    #1;
    check("loss_pre", ifa.sys_rst_n, 1);
    @(posedge clock);
    #1;
    check("loss_rst", {ifa.sys_rst_n, ifa.ready}, 0);
    check("loss_cnt", ifa.loss_count, 1);
    check("loss_gl", ifa.glitch_seen, 0);
    rise_a(n);
    check("loss_reseq", n, 1089);

    // Lock chatter during the filter window.
    ifa.locked = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("chat_loss", ifa.loss_count, 2);
    ifa.locked = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    ifa.locked = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    ifa.locked = 1'b1;
    rise_a(n);
    check("chat_lat", n, 1091);
    check("chat_gl", ifa.glitch_seen, 1);
    check("chat_loss2", ifa.loss_count, 2);

    // Async reset while HOLD count is at 500.
    ifa.locked = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("hold_loss", ifa.loss_count, 3);
    ifa.locked = 1'b1;
    repeat (567) @(posedge clock);
    #1;
    check("hold_pre", {ifa.sys_rst_n, ifa.ready, ifa.glitch_seen}, 3'b001);
    rst_a = 1'b0;
    #1;
    check("hold_arst", {ifa.sys_rst_n, ifa.ready, ifa.loss_count, ifa.glitch_seen}, 0);
    rst_a = 1'b1;
    rise_a(n);
    check("hold_reseq", n, 1091);

    // Tiny-config vector table (FILTER=HOLD=1).
    rst_c = 1'b1;
    for (int i = 0; i < 29; i++) begin
      ifc.locked    = (tbl[i].locked != 0);
      ifc.clr_stats = (tbl[i].clr != 0);
      @(posedge clock);
      #1;
      el = tbl[i].loss[1:0];
      check($sformatf("c_vec%0d", i + 1),
            {ifc.sys_rst_n, ifc.ready, ifc.loss_count, ifc.glitch_seen},
            {(tbl[i].rdy != 0), (tbl[i].rdy != 0), el, (tbl[i].glitch != 0)});
    end
    ifc.clr_stats = 1'b0;

    // Saturation of a 2-bit loss counter, then async clear.
    model_b_reset();
    rst_b = 1'b1;
    repeat (5) begin
      ifb.locked = 1'b1;
      repeat (20) step_b();
      ifb.locked = 1'b0;
      repeat (3) step_b();
    end
    check("b_sat", ifb.loss_count, 3);
    rst_b = 1'b0;
    #1;
    check("b_arst", {ifb.sys_rst_n, ifb.ready, ifb.loss_count, ifb.glitch_seen}, 0);
    model_b_reset();
    #1;
    rst_b = 1'b1;

    // Randomized lock bursts with sporadic stat clears.
    for (int seg = 0; seg < 250; seg++) begin
      hi = $urandom_range(1, 24);
      lo = $urandom_range(1, 4);
      ifb.locked = 1'b1;
      for (int c = 0; c < hi; c++) begin
        ifb.clr_stats = ($urandom_range(0, 15) == 0);
        step_b();
      end
      ifb.locked = 1'b0;
      for (int c = 0; c < lo; c++) begin
        ifb.clr_stats = ($urandom_range(0, 15) == 0);
        step_b();
      end
    end
    ifb.clr_stats = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
